sdf_bitrev_reorder: RTL and testbench

- Downstream stage of sdf_top. Accepts the 64-point NTT result stream, which arrives in bit-reversed order, and re-emits it in natural order.
- Uses a ping-pong pair of 2**addr_width-entry buffers, so back-to-back frames stream with no stall.
- Feeds the natural-order result to the coefficient memory and INTT loader.

---
 rtl/sdf_bitrev_reorder.sv | 134 +++++++++++++
 tb/tb_sdf_bitrev_reorder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 64-point SDF NTT output.
// Ping-pong banks: one frame is written while the previous one is read out.
module sdf_bitrev_reorder #(
  parameter int data_width = 64,
  parameter int addr_width = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  done_tick,
  output logic                  overflow,
  output logic                  dbg_rd_state
);

  localparam int N = 1 << addr_width;
  localparam logic [addr_width-1:0] LAST = addr_width'(N - 1);

  // Handshake: in_valid qualifies in_data for one cycle (no backpressure);
  // out_valid qualifies out_data, out_first and out_last for one cycle.

  typedef enum logic {IDLE, READ} rd_state_t;

  function automatic logic [addr_width-1:0] bitrev(input logic [addr_width-1:0] a);
    logic [addr_width-1:0] r;
    r = '0;
    for (int i = 0; i < addr_width; i++) r[i] = a[addr_width-1-i];
    return r;
  endfunction

  logic [data_width-1:0] mem [0:2*N-1];
  logic [data_width-1:0] mem_q;

  logic [addr_width-1:0] wr_cnt_q, wr_cnt_d;
  logic                  wr_bank_q, wr_bank_d;
  rd_state_t             state_q, state_d;
  logic [addr_width-1:0] rd_cnt_q, rd_cnt_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  overflow_q, overflow_d;
  logic                  s1_valid_q, s1_first_q, s1_last_q;
  logic                  out_valid_q, out_first_q, out_last_q, done_tick_q;
  logic [data_width-1:0] out_data_q;

  logic wr_wrap;
  logic launch;

  assign wr_wrap = in_valid && (wr_cnt_q == LAST);
  // Kept as its own net so the reader launch can be observed independently.
  assign launch  = wr_wrap;

  always_ff @(posedge clk) begin
    if (in_valid) mem[{wr_bank_q, bitrev(wr_cnt_q)}] <= in_data;
    mem_q <= mem[{rd_bank_q, rd_cnt_q}];
  end

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    overflow_d = overflow_q;
    if (in_valid) wr_cnt_d = wr_cnt_q + 1'b1;
    if (wr_wrap) wr_bank_d = ~wr_bank_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d   = READ;
          rd_cnt_d  = '0;
          rd_bank_d = wr_bank_q;
        end
      end
      READ: begin
        if (rd_cnt_q == LAST) begin
          rd_cnt_d = '0;
          if (launch) rd_bank_d = wr_bank_q;
          else        state_d   = IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          // A launch mid-read would clobber the frame in flight; drop it.
          if (launch) overflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      overflow_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_tick_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      overflow_q  <= overflow_d;
      s1_valid_q  <= (state_q == READ);
      s1_first_q  <= (state_q == READ) && (rd_cnt_q == '0);
      s1_last_q   <= (state_q == READ) && (rd_cnt_q == LAST);
      out_valid_q <= s1_valid_q;
      out_first_q <= s1_first_q;
      out_last_q  <= s1_last_q;
      done_tick_q <= out_last_q;
      if (s1_valid_q) out_data_q <= mem_q;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_first    = out_first_q;
  assign out_last     = out_last_q;
  assign done_tick    = done_tick_q;
  assign overflow     = overflow_q;
  assign dbg_rd_state = (state_q == READ);

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Bench for sdf_bitrev_reorder: frames are built in natural order, scrambled
// into bit-reversed arrival order, and the output is matched against a queue.
module tb_sdf_bitrev_reorder;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int N  = 64;

  typedef logic [DW-1:0] frame_t [N];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_first;
  logic          out_last;
  logic          done_tick;
  logic          overflow;
  logic          dbg_rd_state;

  sdf_bitrev_reorder #(.data_width(DW), .addr_width(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_first(out_first),
    .out_last(out_last), .done_tick(done_tick), .overflow(overflow),
    .dbg_rd_state(dbg_rd_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int t_last_wr = 0;
  int t_first_out = 0;
  int run_len = 0;
  int last_run = 0;
  int done_cnt = 0;
  int out_idx = 0;
  logic prev_last = 1'b0;

  function automatic logic [5:0] br6(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
  endfunction

  // Scoreboard: every out_valid beat pops the next natural-order word.
  always @(negedge clk) begin
    if (!rst_n) begin
      out_idx = 0; prev_last = 1'b0; run_len = 0;
    end else begin
      vectors++;
      if (done_tick !== prev_last) begin
        miscompares++;
        $display("FAIL done_tick: got %b want %b (cyc %0d)", done_tick, prev_last, cyc);
      end
      if (done_tick === 1'b1) done_cnt++;
      if (out_valid === 1'b1) begin
        logic [DW-1:0] e;
        if (run_len == 0) t_first_out = cyc;
        run_len++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out: out_data %0d with empty queue (cyc %0d)", out_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            miscompares++;
            $display("FAIL out_data idx %0d: got %0d want %0d", out_idx, out_data, e);
          end
          vectors++;
          if (out_first !== (out_idx == 0)) begin
            miscompares++;
            $display("FAIL out_first idx %0d: got %b want %b", out_idx, out_first, out_idx == 0);
          end
          vectors++;
          if (out_last !== (out_idx == N-1)) begin
            miscompares++;
            $display("FAIL out_last idx %0d: got %b want %b", out_idx, out_last, out_idx == N-1);
          end
        end
        out_idx = (out_idx + 1) % N;
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      prev_last = out_last;
    end
  end

  task automatic send_frame(input frame_t nat, input bit gaps);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data  = nat[br6(6'(k))];
      @(posedge clk); #1;
      if (k == N-1) t_last_wr = cyc;
      else if (gaps) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        @(posedge clk); #1;
      end
    end
    for (int j = 0; j < N; j++) exp_q.push_back(nat[j]);
  endtask

  task automatic idle_input();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && out_valid === 1'b0) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    vectors++;
    if ({out_valid, out_first, out_last, done_tick, overflow} !== 5'b0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL %s: v/f/l/d/o=%b%b%b%b%b data=%0d want all 0", tag,
               out_valid, out_first, out_last, done_tick, overflow, out_data);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_values");
    vectors++;
    if (dbg_rd_state !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want 0", dbg_rd_state);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    frame_t nat;
    int d0 = done_cnt;
    for (int j = 0; j < N; j++) nat[j] = DW'(j);
    send_frame(nat, 1'b0);
    idle_input();
    wait_drain();
    check_int("single_latency", t_first_out - t_last_wr, 2);
    check_int("single_burst_len", last_run, N);
    check_int("single_done_ticks", done_cnt - d0, 1);
  endtask

  task automatic test_back_to_back();
    frame_t nat;
    int d0 = done_cnt;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < N; j++) nat[j] = DW'(j + 100 * f);
      send_frame(nat, 1'b0);
    end
    idle_input();
    wait_drain();
    check_int("b2b_burst_len", last_run, 3 * N);
    check_int("b2b_done_ticks", done_cnt - d0, 3);
  endtask

  task automatic test_golden();
    frame_t nat;
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < N; j++) nat[j] = DW'($urandom_range(0, 7680));
      send_frame(nat, 1'b0);
      idle_input();
      wait_drain();
      check_int("golden_burst_len", last_run, N);
    end
    for (int j = 0; j < N; j++) nat[j] = {$urandom, $urandom};
    send_frame(nat, 1'b0);
    idle_input();
    wait_drain();
    check_int("fullwidth_burst_len", last_run, N);
  endtask

  task automatic test_toggle();
    frame_t nat;
    for (int j = 0; j < N; j++) nat[j] = DW'(j);
    send_frame(nat, 1'b1);
    idle_input();
    wait_drain();
    check_int("toggle_latency", t_first_out - t_last_wr, 2);
    check_int("toggle_burst_len", last_run, N);
  endtask

  task automatic test_reset_mid_frame();
    frame_t nat;
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    idle_input();
    #1;
    check_outputs_zero("reset_async_mid_frame");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < N; j++) nat[j] = DW'(1000 + j);
    send_frame(nat, 1'b0);
    idle_input();
    wait_drain();
    check_int("post_reset_burst_len", last_run, N);
    check_int("post_reset_latency", t_first_out - t_last_wr, 2);
  endtask

  task automatic test_overflow();
    frame_t nat;
    bit hit = 1'b0;
    for (int j = 0; j < N; j++) nat[j] = DW'($urandom_range(0, 7680));
    check_int("overflow_before", int'(overflow), 0);
    send_frame(nat, 1'b0);
    idle_input();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (dbg_rd_state === 1'b1 && dut.rd_cnt_q == 6'd10) begin hit = 1'b1; break; end
    end
    check_int("overflow_reach_rd10", int'(hit), 1);
    force dut.launch = 1'b1;
    @(posedge clk); #1;
    release dut.launch;
    check_int("overflow_set", int'(overflow), 1);
    wait_drain();
    check_int("overflow_frame_len", last_run, N);
    check_int("overflow_sticky", int'(overflow), 1);
    for (int j = 0; j < N; j++) nat[j] = DW'(j + 5);
    send_frame(nat, 1'b0);
    idle_input();
    wait_drain();
    check_int("overflow_sticky2", int'(overflow), 1);
    rst_n = 1'b0;
    #1;
    check_int("overflow_cleared", int'(overflow), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_golden();
    test_toggle();
    test_reset_mid_frame();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
